// File: rtl/cache_writeback_ctrl_pkg.sv
// Shared cache package: writeback FSM state encoding
// and address-offset helpers.
package cache_writeback_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_AW,
        S_W,
        S_B,
        S_CLR,
        S_DONE
    } wb_state_e;

    localparam int WORD_BYTES = 4;
    localparam int OFFSET_W_DEFAULT = 5;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_writeback_ctrl.sv
// Dirty-line writeback controller: checks the dirty bit,
// bursts a victim line out, then clears the dirty bit.
module cache_writeback_ctrl
    import cache_writeback_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 8
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        evict_req,
    input  logic [INDEX_W-1:0]                          evict_index,
    input  logic [32-INDEX_W-offset_w(LINE_WORDS)-1:0]  evict_tag,
    input  logic [LINE_WORDS*32-1:0]                    evict_line,
    output logic                                        evict_ready,
    output logic                                        evict_done,
    output logic                                        evict_dirty,
    output logic [INDEX_W-1:0]                          dirty_addr,
    output logic                                        dirty_we,
    output logic                                        dirty_din,
    input  logic                                        dirty_dout,
    output logic                                        aw_valid,
    output logic [31:0]                                 aw_addr,
    input  logic                                        aw_ready,
    output logic                                        w_valid,
    output logic [31:0]                                 w_data,
    output logic                                        w_last,
    input  logic                                        w_ready,
    input  logic                                        b_valid
);

    localparam int OFF_W = offset_w(LINE_WORDS);
    localparam int TAG_W = 32 - INDEX_W - OFF_W;
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    wb_state_e          state_q;
    wb_state_e          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               dirty_q;
    logic               dirty_d;
    logic               capture;
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        line_q [LINE_WORDS];

    assign evict_dirty = dirty_q;

    // State, beat counter and captured dirty flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
        end
    end

    // Victim snapshot, taken once when the request is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
            tag_q <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= '0;
            end
        end else if (capture) begin
            idx_q <= evict_index;
            tag_q <= evict_tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= evict_line[k*32 +: 32];
            end
        end
    end

    // Next-state and output decode; outputs idle unless a state drives them
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dirty_d     = dirty_q;
        capture     = 1'b0;
        evict_ready = 1'b0;
        evict_done  = 1'b0;
        dirty_addr  = '0;
        dirty_we    = 1'b0;
        dirty_din   = 1'b0;
        aw_valid    = 1'b0;
        aw_addr     = '0;
        w_valid     = 1'b0;
        w_data      = '0;
        w_last      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                evict_ready = 1'b1;
                if (evict_req) begin
                    capture = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                dirty_addr = idx_q;
                state_d    = S_CHK;
            end
            S_CHK: begin
                dirty_d = dirty_dout;
                if (dirty_dout) begin
                    cnt_d   = '0;
                    state_d = S_AW;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_AW: begin
                aw_valid = 1'b1;
                aw_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
                if (aw_ready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                w_valid = 1'b1;
                w_data  = line_q[cnt_q];
                w_last  = (cnt_q == LAST);
                if (w_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_B: begin
                if (b_valid) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                dirty_addr = idx_q;
                dirty_we   = 1'b1;
                dirty_din  = 1'b0;
                state_d    = S_DONE;
            end
            S_DONE: begin
                evict_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Randomized bench for cache_writeback_ctrl with a
// transaction-level reference and a dirty-store model.
module tb_cache_writeback_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         evict_req;
    logic [7:0]   evict_index;
    logic [18:0]  tag_in;
    logic [511:0] line_in;
    logic         aw_ready;
    logic         w_ready;
    logic         b_valid;
    bit           sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic        r8, d8, dy8, we8, din8, dout8, awv8, wv8, wl8;
    logic [7:0]  da8;
    logic [31:0] awa8, wd8;
    logic        r16, d16, dy16, we16, din16, dout16, awv16, wv16, wl16;
    logic [7:0]  da16;
    logic [31:0] awa16, wd16;

    logic        o_ready, o_done, o_dirty, o_we, o_din, o_awv, o_wv, o_wl;
    logic [7:0]  o_daddr;
    logic [31:0] o_awa, o_wd;

    assign o_ready = sel ? r16 : r8;
    assign o_done  = sel ? d16 : d8;
    assign o_dirty = sel ? dy16 : dy8;
    assign o_we    = sel ? we16 : we8;
    assign o_din   = sel ? din16 : din8;
    assign o_daddr = sel ? da16 : da8;
    assign o_awv   = sel ? awv16 : awv8;
    assign o_awa   = sel ? awa16 : awa8;
    assign o_wv    = sel ? wv16 : wv8;
    assign o_wd    = sel ? wd16 : wd8;
    assign o_wl    = sel ? wl16 : wl8;

    cache_writeback_ctrl #(.LINE_WORDS(8), .INDEX_W(8)) u8 (
        .clk(clk), .resetn(resetn),
        .evict_req(evict_req & ~sel), .evict_index(evict_index),
        .evict_tag(tag_in), .evict_line(line_in[255:0]),
        .evict_ready(r8), .evict_done(d8), .evict_dirty(dy8),
        .dirty_addr(da8), .dirty_we(we8), .dirty_din(din8),
        .dirty_dout(dout8),
        .aw_valid(awv8), .aw_addr(awa8), .aw_ready(aw_ready),
        .w_valid(wv8), .w_data(wd8), .w_last(wl8), .w_ready(w_ready),
        .b_valid(b_valid)
    );

    cache_writeback_ctrl #(.LINE_WORDS(16), .INDEX_W(8)) u16 (
        .clk(clk), .resetn(resetn),
        .evict_req(evict_req & sel), .evict_index(evict_index),
        .evict_tag(tag_in[17:0]), .evict_line(line_in),
        .evict_ready(r16), .evict_done(d16), .evict_dirty(dy16),
        .dirty_addr(da16), .dirty_we(we16), .dirty_din(din16),
        .dirty_dout(dout16),
        .aw_valid(awv16), .aw_addr(awa16), .aw_ready(aw_ready),
        .w_valid(wv16), .w_data(wd16), .w_last(wl16), .w_ready(w_ready),
        .b_valid(b_valid)
    );

    // Dirty-bit stores: registered read, write port from the DUT,
    // plus a preset port used by the bench to seed a line's state.
    bit         mem [2][256];
    logic       pre_en;
    bit         pre_s;
    logic [7:0] pre_idx;
    logic       pre_val;

    always @(posedge clk) begin
        if (pre_en) mem[pre_s][pre_idx] <= pre_val;
        if (we8) mem[0][da8] <= din8;
        if (we16) mem[1][da16] <= din16;
        dout8  <= mem[0][da8];
        dout16 <= mem[1][da16];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_dirty", o_dirty, 0);
        chk("rst_we", o_we, 0);
        chk("rst_din", o_din, 0);
        chk("rst_daddr", o_daddr, 0);
        chk("rst_awv", o_awv, 0);
        chk("rst_awa", o_awa, 0);
        chk("rst_wv", o_wv, 0);
        chk("rst_wl", o_wl, 0);
        chk("rst_wd", o_wd, 0);
    endtask

    task automatic rand_line();
        for (int k = 0; k < 16; k++) line_in[k*32 +: 32] = $urandom;
    endtask

    // One eviction, checked cycle by cycle against handshake-level
    // expectations; wmode 0 = always ready, 1 = w_ready toggles,
    // 2 = random readies. abort_at >= 0 resets after that many beats.
    task automatic run_evict(input bit s16, input logic [7:0] idx,
                             input bit dirty, input int wmode,
                             input int abort_at);
        int lw, off, tw, n, beats;
        bit aw_done, b_acc, clr_seen, done_seen, fin;
        bit exp_aw, exp_w, exp_we, exp_done, exp_ready, in_b;
        logic [18:0]  ctag;
        logic [511:0] cline;
        logic [63:0]  exp_addr;
        lw  = s16 ? 16 : 8;
        off = s16 ? 6 : 5;
        tw  = 32 - 8 - off;
        ctag  = tag_in;
        cline = line_in;
        exp_addr = ((64'(ctag) & ((64'd1 << tw) - 1)) << (8 + off))
                 | (64'(idx) << off);
        sel = s16;
        @(negedge clk);
        pre_en = 1; pre_s = s16; pre_idx = idx; pre_val = dirty;
        evict_req = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        @(negedge clk);
        pre_en = 0;
        chk("ready_idle", o_ready, 1);
        evict_req = 1; evict_index = idx;
        tag_in = ctag; line_in = cline;
        n = 0; beats = 0; aw_done = 0; b_acc = 0;
        clr_seen = 0; done_seen = 0; fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            n++;
            exp_aw    = dirty && n >= 3 && !aw_done;
            exp_w     = aw_done && beats < lw;
            exp_we    = b_acc && !clr_seen;
            exp_done  = dirty ? (clr_seen && !done_seen) : (n == 3);
            exp_ready = done_seen;
            chk("aw_valid", o_awv, exp_aw);
            chk("w_valid", o_wv, exp_w);
            chk("dirty_we", o_we, exp_we);
            chk("evict_done", o_done, exp_done);
            chk("evict_ready", o_ready, exp_ready);
            if (n == 1) chk("rd_addr", o_daddr, idx);
            if (exp_aw) chk("aw_addr", o_awa, exp_addr);
            if (exp_w) begin
                chk("w_data", o_wd, cline[beats*32 +: 32]);
                chk("w_last", o_wl, beats == lw - 1);
            end
            if (exp_we) begin
                chk("clr_addr", o_daddr, idx);
                chk("clr_din", o_din, 0);
                clr_seen = 1;
            end
            if (exp_done) begin
                chk("evict_dirty", o_dirty, dirty);
                done_seen = 1;
            end
            if (exp_ready) begin
                fin = 1;
            end else if (abort_at >= 0 && beats == abort_at) begin
                fin = 1;
            end else begin
                evict_req   = 1'($urandom_range(0, 1));
                evict_index = 8'($urandom);
                tag_in      = 19'($urandom);
                rand_line();
                aw_ready = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (wmode == 0) w_ready = 1;
                else if (wmode == 1) w_ready = n[0];
                else w_ready = 1'($urandom_range(0, 1));
                in_b    = (beats == lw) && !b_acc;
                b_valid = ($urandom_range(0, 2) == 0);
                if (in_b && b_valid) b_acc = 1;
                if (exp_aw && aw_ready) aw_done = 1;
                if (exp_w && w_ready) beats++;
            end
        end
        if (!fin) chk("timeout", 1, 0);
        evict_req = 0; b_valid = 0; aw_ready = 0; w_ready = 0;
        if (abort_at < 0) begin
            chk("beats", beats, dirty ? lw : 0);
            chk("dirty_cleared", mem[s16][idx], 0);
        end else begin
            resetn = 0;
            #1;
            chk_reset();
            @(negedge clk);
            chk("abort_we", o_we, 0);
            resetn = 1;
            repeat (4) begin
                @(negedge clk);
                chk("abort_we_after", o_we, 0);
            end
            chk("abort_ready", o_ready, 1);
            chk("still_dirty", mem[s16][idx], 1);
        end
    endtask

    initial begin
        resetn = 0; evict_req = 0; evict_index = 0; tag_in = 0;
        line_in = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        pre_en = 0; pre_s = 0; pre_idx = 0; pre_val = 0; sel = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        resetn = 1;
        @(negedge clk);
        chk_reset();

        tag_in = 19'($urandom); rand_line();
        run_evict(0, 8'h12, 0, 0, -1);

        tag_in = 19'h1ABCD;
        for (int k = 0; k < 16; k++) line_in[k*32 +: 32] = 32'h100 + k;
        run_evict(0, 8'h12, 1, 0, -1);

        tag_in = 19'($urandom); rand_line();
        run_evict(0, 8'($urandom), 1, 1, -1);

        for (int i = 0; i < 10; i++) begin
            tag_in = 19'($urandom); rand_line();
            run_evict(0, 8'($urandom), 1'($urandom_range(0, 1)), 2, -1);
        end

        tag_in = 19'($urandom); rand_line();
        run_evict(1, 8'hFF, 1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            tag_in = 19'($urandom); rand_line();
            run_evict(1, 8'($urandom), 1'($urandom_range(0, 1)), 2, -1);
        end

        tag_in = 19'($urandom); rand_line();
        run_evict(0, 8'h34, 1, 0, 3);

        tag_in = 19'($urandom); rand_line();
        run_evict(0, 8'h34, 1, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
